// File: rtl/systolic_feeder_4x4_pkg.sv
// Shared constants and types for the systolic array operand path.
package systolic_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 32;
    localparam int ARRAY_DIM = 4;

    typedef enum logic {
        IDLE,
        STREAM
    } feeder_state_t;

    localparam logic BUF_A = 1'b0;
    localparam logic BUF_B = 1'b1;

endpackage

// File: rtl/systolic_feeder_4x4_skew_line.sv
// N-stage zero-reset delay line for one operand lane of the skewed wavefront.
// Only present when SYSTOLIC_SKEW_EN is defined.
`ifdef SYSTOLIC_SKEW_EN
module systolic_skew_line #(
    parameter int W = 8,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < N; s++) sr[s] <= '0;
        end else begin
            sr[0] <= d;
            for (int unsigned s = 1; s < N; s++) sr[s] <= sr[s-1];
        end
    end

    assign q = sr[N-1];

endmodule
`endif

// File: rtl/systolic_feeder_4x4.sv
// Operand feeder for the 4x4 multiply array: buffers A (4xDEPTH) and B (DEPTHx4),
// streams one k per cycle on start. Define SYSTOLIC_SKEW_EN for diagonal skew.
module systolic_feeder_4x4 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int KW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int IW    = (KW > 2) ? KW : 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IW-1:0]     wr_row,
    input  logic [IW-1:0]     wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              stream_valid,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic [DATA_W-1:0] b1,
    output logic [DATA_W-1:0] b2,
    output logic [DATA_W-1:0] b3,
    output logic [DATA_W-1:0] b4
);

    import systolic_pkg::*;

`ifdef SYSTOLIC_SKEW_EN
    localparam int LAST = DEPTH + 2;
`else
    localparam int LAST = DEPTH - 1;
`endif
    localparam int CW = (LAST > 0) ? $clog2(LAST + 1) : 1;

    logic [DATA_W-1:0] abuf [ARRAY_DIM][DEPTH];
    logic [DATA_W-1:0] bbuf [DEPTH][ARRAY_DIM];

    feeder_state_t     state;
    logic [CW-1:0]     k;
    logic [CW-1:0]     nidx;
    logic              wr_ok;
    logic [DATA_W-1:0] a_q    [ARRAY_DIM];
    logic [DATA_W-1:0] b_q    [ARRAY_DIM];
    logic [DATA_W-1:0] a_col  [ARRAY_DIM];
    logic [DATA_W-1:0] b_row  [ARRAY_DIM];
    logic [DATA_W-1:0] a_lane [ARRAY_DIM];
    logic [DATA_W-1:0] b_lane [ARRAY_DIM];

    assign wr_ok = wr_en && (state == IDLE) && !start;

    // Index decode doubles as the range check: out-of-range writes match nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ARRAY_DIM; i++)
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    abuf[i][d] <= '0;
                    bbuf[d][i] <= '0;
                end
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < ARRAY_DIM; i++)
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    if (wr_sel == BUF_A && wr_row == IW'(i) && wr_col == IW'(d))
                        abuf[i][d] <= wr_data;
                    if (wr_sel == BUF_B && wr_row == IW'(d) && wr_col == IW'(i))
                        bbuf[d][i] <= wr_data;
                end
        end
    end

    // Operand slice for the next stream cycle; indices past DEPTH-1 read as zero.
    always_comb begin
        nidx = (state == IDLE) ? '0 : k + 1'b1;
        for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
            a_col[i] = '0;
            b_row[i] = '0;
        end
        for (int unsigned d = 0; d < DEPTH; d++)
            if (nidx == CW'(d))
                for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                    a_col[i] = abuf[i][d];
                    b_row[i] = bbuf[d][i];
                end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            k            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            stream_valid <= 1'b0;
            for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= STREAM;
                        k            <= '0;
                        busy         <= 1'b1;
                        stream_valid <= 1'b1;
                    end
                    for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                        a_q[i] <= start ? a_col[i] : '0;
                        b_q[i] <= start ? b_row[i] : '0;
                    end
                end
                STREAM: begin
                    if (k == CW'(LAST)) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        stream_valid <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                    for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                        a_q[i] <= (k == CW'(LAST)) ? '0 : a_col[i];
                        b_q[i] <= (k == CW'(LAST)) ? '0 : b_row[i];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_SKEW_EN
    for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
        if (g == 0) begin : g_direct
            assign a_lane[g] = a_q[g];
            assign b_lane[g] = b_q[g];
        end else begin : g_delay
            systolic_skew_line #(.W(DATA_W), .N(g)) u_skew_a (
                .clk(clk), .rst(rst), .d(a_q[g]), .q(a_lane[g])
            );
            systolic_skew_line #(.W(DATA_W), .N(g)) u_skew_b (
                .clk(clk), .rst(rst), .d(b_q[g]), .q(b_lane[g])
            );
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
            a_lane[i] = a_q[i];
            b_lane[i] = b_q[i];
        end
    end
`endif

    assign a1 = a_lane[0];
    assign a2 = a_lane[1];
    assign a3 = a_lane[2];
    assign a4 = a_lane[3];
    assign b1 = b_lane[0];
    assign b2 = b_lane[1];
    assign b3 = b_lane[2];
    assign b4 = b_lane[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Self-checking bench for systolic_feeder_4x4 (DEPTH=4) with a position-based reference model.
module tb_systolic_feeder_4x4;

    localparam int DEPTH = 4;
`ifdef SYSTOLIC_SKEW_EN
    localparam int SKEW = 1;
    localparam int LEN  = DEPTH + 3;
`else
    localparam int SKEW = 0;
    localparam int LEN  = DEPTH;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       wr_sel;
    logic [1:0] wr_row;
    logic [1:0] wr_col;
    logic [7:0] wr_data;
    logic       start;
    logic       busy, done, stream_valid;
    logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic [7:0] a_o [4];
    logic [7:0] b_o [4];

    int n_cmp = 0;
    int n_bad = 0;

    systolic_feeder_4x4 #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .stream_valid(stream_valid), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4)
    );

    assign a_o[0] = a1; assign a_o[1] = a2; assign a_o[2] = a3; assign a_o[3] = a4;
    assign b_o[0] = b1; assign b_o[1] = b2; assign b_o[2] = b3; assign b_o[3] = b4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: buffers as plain arrays, job progress as an integer position (-1 = idle).
    logic [7:0] ma [4][DEPTH];
    logic [7:0] mb [DEPTH][4];
    int         pos = -1;
    logic       done_m = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                for (int d = 0; d < DEPTH; d++) begin
                    ma[i][d] <= '0;
                    mb[d][i] <= '0;
                end
            pos    <= -1;
            done_m <= 1'b0;
        end else if (pos < 0) begin
            done_m <= 1'b0;
            if (start) pos <= 0;
            else if (wr_en) begin
                if (!wr_sel && int'(wr_col) < DEPTH) ma[wr_row][wr_col] <= wr_data;
                if (wr_sel && int'(wr_row) < DEPTH)  mb[wr_row][wr_col] <= wr_data;
            end
        end else begin
            done_m <= (pos == LEN - 1);
            pos    <= (pos == LEN - 1) ? -1 : pos + 1;
        end
    end

    function automatic logic [7:0] exp_a(input int i);
        int d;
        if (pos < 0) return '0;
        d = pos - i * SKEW;
        if (d >= 0 && d < DEPTH) return ma[i][d];
        return '0;
    endfunction

    function automatic logic [7:0] exp_b(input int j);
        int d;
        if (pos < 0) return '0;
        d = pos - j * SKEW;
        if (d >= 0 && d < DEPTH) return mb[d][j];
        return '0;
    endfunction

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(pos >= 0));
        chk("stream_valid", 32'(stream_valid), 32'(pos >= 0));
        chk("done", 32'(done), 32'(done_m));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a%0d", i + 1), 32'(a_o[i]), 32'(exp_a(i)));
            chk($sformatf("b%0d", i + 1), 32'(b_o[i]), 32'(exp_b(i)));
        end
    end

    task automatic do_write(input logic sel, input int r, input int c, input int v);
        @(negedge clk);
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = r[1:0];
        wr_col  = c[1:0];
        wr_data = v[7:0];
    endtask

    // Leaves the caller at the negedge of stream cycle k=0.
    task automatic pulse_start();
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int nd;
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sv", 32'(stream_valid), 0);
        chk("rst_a1", 32'(a1), 0);
        #2 rst = 1'b1;

        // Identity job: A = I, B[k][j] = 4k+j+1
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 4; kk++) do_write(1'b0, i, kk, (i == kk) ? 1 : 0);
        for (int kk = 0; kk < 4; kk++)
            for (int j = 0; j < 4; j++) do_write(1'b1, kk, j, 4 * kk + j + 1);
        pulse_start();
        for (int kk = 0; kk < 4; kk++) begin
            if (kk > 0) @(negedge clk);
            chk("id_b1", 32'(b1), 32'(4 * kk + 1));
            chk("id_b4", 32'(b4), 32'(4 * kk + 4));
            chk("id_a1", 32'(a1), (kk == 0) ? 1 : 0);
            chk("id_sv", 32'(stream_valid), 1);
        end
        @(negedge clk);
        chk("id_done", 32'(done), 1);
        chk("id_busy_off", 32'(busy), 0);

        // Writes while busy and coincident with start are dropped
        pulse_start();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd9;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("blk_done", 32'(done), 1);
        wr_en = 1'b1; wr_data = 8'd7; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        chk("blk_a1", 32'(a1), 1);
        chk("blk_busy", 32'(busy), 1);
        repeat (4) @(negedge clk);
        chk("blk_done2", 32'(done), 1);

        // Start while busy is ignored
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("one_done", 32'(nd), 1);

        // Back-to-back job started in the done cycle
        pulse_start();
        repeat (4) @(negedge clk);
        chk("b2b_done", 32'(done), 1);
        chk("b2b_gap", 32'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_b1", 32'(b1), 1);
        repeat (4) @(negedge clk);
        chk("b2b_done2", 32'(done), 1);

        // Reset mid-stream aborts and clears buffers
        pulse_start();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_b1", 32'(b1), 0);
        chk("mid_b4", 32'(b4), 0);
        chk("mid_busy", 32'(busy), 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_no_done", 32'(nd), 0);
        #2 rst = 1'b1;
        pulse_start();
        chk("mid_clr_b1", 32'(b1), 0);
        chk("mid_clr_a1", 32'(a1), 0);
        chk("mid_clr_sv", 32'(stream_valid), 1);
        repeat (4) @(negedge clk);
        chk("mid_done", 32'(done), 1);

        // Randomized traffic against the model
        repeat (400) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 1'($urandom_range(0, 1));
            wr_row  = 2'($urandom_range(0, 3));
            wr_col  = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom_range(0, 255));
            start   = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
